// File: rtl/mica_pkg.sv
// Shared definitions for the Mica2 instruction sequencer: state encoding
// and the control-word bit positions the sequencer acts on.
package mica_pkg;

  localparam int INSTR_W = 8;
  localparam int CTL_W   = 7;

  localparam int CTL_MEM = 0;
  localparam int CTL_WB  = 1;
  localparam int CTL_BR  = 3;
  localparam int CTL_HLT = 6;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_MEM    = 3'd3,
    S_EXEC   = 3'd4,
    S_HALT   = 3'd5
  } state_t;

endpackage

// File: rtl/mica_sequencer_if.sv
// Sequencer-facing bus bundle: instruction fetch, decode ROM, data memory
// and the datapath strobes.
interface mica_sequencer_if #(parameter int PC_W = 8);
  logic                 imem_req;
  logic [PC_W-1:0]      imem_addr;
  logic                 imem_ack;
  logic [7:0]           imem_data;
  logic [3:0]           op;
  logic [6:0]           ctl;
  logic                 dmem_req;
  logic                 dmem_ack;
  logic                 flag_z;
  logic [6:0]           ctl_q;
  logic [3:0]           operand;
  logic                 ex_stb;
  logic                 wb_stb;
  logic                 halted;

  modport master (
    output imem_req, imem_addr, op, dmem_req, ctl_q, operand, ex_stb, wb_stb, halted,
    input  imem_ack, imem_data, ctl, dmem_ack, flag_z
  );

  modport slave (
    input  imem_req, imem_addr, op, dmem_req, ctl_q, operand, ex_stb, wb_stb, halted,
    output imem_ack, imem_data, ctl, dmem_ack, flag_z
  );
endinterface

// File: rtl/mica_pc.sv
// Program counter: reset value, modulo increment, and a page-local load
// that replaces only the low nibble.
module mica_pc #(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = 8'h00
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            inc,
  input  logic            load,
  input  logic [3:0]      load_lo,
  output logic [PC_W-1:0] pc
);

  always_ff @(posedge clk) begin
    if (rst)       pc <= RESET_PC;
    else if (load) pc <= {pc[PC_W-1:4], load_lo};
    else if (inc)  pc <= PC_W'(pc + 1'b1);
  end

endmodule

// File: rtl/mica_sequencer.sv
// Fetch/decode/execute sequencer: owns the PC, registers the instruction and
// the decode ROM's control word, and steps through MEM/EXEC/HALT.
module mica_sequencer
  import mica_pkg::*;
#(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = 8'h00
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  mica_sequencer_if.master  bus
);

  state_t               state;
  logic [INSTR_W-1:0]   ir;
  logic [CTL_W-1:0]     ctl_q;
  logic                 imem_req, dmem_req, ex_stb, wb_stb, halted;
  logic [PC_W-1:0]      pc;
  logic                 pc_inc, pc_load;

  // Halt retires in DECODE, so its PC advance happens there; everything
  // else advances (or branches) at the end of EXEC.
  assign pc_load = (state == S_EXEC) && ctl_q[CTL_BR] && bus.flag_z;
  assign pc_inc  = ((state == S_EXEC) && !pc_load) ||
                   ((state == S_DECODE) && bus.ctl[CTL_HLT]);

  mica_pc #(.PC_W(PC_W), .RESET_PC(RESET_PC)) u_pc (
    .clk     (clk),
    .rst     (rst),
    .inc     (pc_inc),
    .load    (pc_load),
    .load_lo (ir[3:0]),
    .pc      (pc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      ir       <= '0;
      ctl_q    <= '0;
      imem_req <= 1'b0;
      dmem_req <= 1'b0;
      ex_stb   <= 1'b0;
      wb_stb   <= 1'b0;
      halted   <= 1'b0;
    end else begin
      ex_stb <= 1'b0;
      wb_stb <= 1'b0;
      case (state)
        S_IDLE: if (run) begin
          state    <= S_FETCH;
          imem_req <= 1'b1;
        end
        S_FETCH: if (bus.imem_ack) begin
          ir       <= bus.imem_data;
          imem_req <= 1'b0;
          state    <= S_DECODE;
        end
        S_DECODE: begin
          ctl_q <= bus.ctl;
          if (bus.ctl[CTL_HLT]) begin
            state  <= S_HALT;
            halted <= 1'b1;
          end else if (bus.ctl[CTL_MEM]) begin
            state    <= S_MEM;
            dmem_req <= 1'b1;
          end else begin
            state  <= S_EXEC;
            ex_stb <= 1'b1;
            wb_stb <= bus.ctl[CTL_WB];
          end
        end
        S_MEM: if (bus.dmem_ack) begin
          dmem_req <= 1'b0;
          state    <= S_EXEC;
          ex_stb   <= 1'b1;
          wb_stb   <= ctl_q[CTL_WB];
        end
        S_EXEC: begin
          state    <= S_FETCH;
          imem_req <= 1'b1;
        end
        S_HALT: if (run) begin
          state    <= S_FETCH;
          halted   <= 1'b0;
          imem_req <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.imem_req  = imem_req;
  assign bus.imem_addr = pc;
  assign bus.op        = ir[7:4];
  assign bus.operand   = ir[3:0];
  assign bus.ctl_q     = ctl_q;
  assign bus.dmem_req  = dmem_req;
  assign bus.ex_stb    = ex_stb;
  assign bus.wb_stb    = wb_stb;
  assign bus.halted    = halted;

endmodule

// File: tb/tb_mica_sequencer.sv
// Directed bench for mica_sequencer: drives inputs and samples outputs on the
// falling edge, with a small decode-ROM table behind op/ctl.
module tb_mica_sequencer;

  logic clk = 1'b0;
  logic rst, run;
  always #5 clk = ~clk;

  mica_sequencer_if #(.PC_W(8)) bus();

  mica_sequencer #(.PC_W(8), .RESET_PC(8'h00)) dut (
    .clk (clk),
    .rst (rst),
    .run (run),
    .bus (bus)
  );

  logic [6:0] rom [16];
  assign bus.ctl = rom[bus.op];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Entered at a falling edge while the DUT is in FETCH.
  task automatic do_instr(input logic [7:0] ins, input int dwait, input logic fz,
                          input logic exp_mem, input logic exp_wb,
                          input logic [6:0] exp_ctl, input logic [7:0] exp_pc);
    chk("imem_req_fetch", bus.imem_req, 1);
    bus.imem_ack  = 1'b1;
    bus.imem_data = ins;
    tick();
    bus.imem_ack  = 1'b0;
    bus.imem_data = 8'h00;
    chk("imem_req_drop", bus.imem_req, 0);
    chk("op", bus.op, ins[7:4]);
    tick();
    if (exp_mem) begin
      for (int k = 0; k <= dwait; k++) begin
        chk("dmem_req_hold", bus.dmem_req, 1);
        chk("ex_stb_in_mem", bus.ex_stb, 0);
        if (k == dwait) bus.dmem_ack = 1'b1;
        tick();
      end
      bus.dmem_ack = 1'b0;
    end
    chk("ex_stb", bus.ex_stb, 1);
    chk("wb_stb", bus.wb_stb, exp_wb);
    chk("dmem_req_exec", bus.dmem_req, 0);
    chk("ctl_q", bus.ctl_q, exp_ctl);
    chk("operand", bus.operand, ins[3:0]);
    bus.flag_z = fz;
    tick();
    bus.flag_z = 1'b0;
    chk("ex_stb_pulse", bus.ex_stb, 0);
    chk("wb_stb_pulse", bus.wb_stb, 0);
    chk("imem_req_refetch", bus.imem_req, 1);
    chk("imem_addr_next", bus.imem_addr, exp_pc);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rom[i] = 7'h00;
    rom[1] = 7'h02;
    rom[2] = 7'h05;
    rom[3] = 7'h29;
    rom[4] = 7'h51;
    rst = 1'b1; run = 1'b0;
    bus.imem_ack = 1'b0; bus.imem_data = 8'h00;
    bus.dmem_ack = 1'b0; bus.flag_z = 1'b0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_imem_req", bus.imem_req, 0);
    chk("rst_dmem_req", bus.dmem_req, 0);
    chk("rst_ex_stb", bus.ex_stb, 0);
    chk("rst_wb_stb", bus.wb_stb, 0);
    chk("rst_halted", bus.halted, 0);
    chk("rst_pc", bus.imem_addr, 8'h00);
    chk("rst_ctl_q", bus.ctl_q, 7'h00);
    tick();
    chk("idle_no_run", bus.imem_req, 0);

    // Zero-wait WB instruction: strobes in cycle 3, refetch in cycle 4.
    run = 1'b1; tick(); run = 1'b0;
    chk("run_fetch_req", bus.imem_req, 1);
    chk("run_fetch_addr", bus.imem_addr, 8'h00);
    do_instr(8'h15, 0, 1'b0, 1'b0, 1'b1, 7'h02, 8'h01);

    // Reset while FETCH is outstanding, then a late ack.
    rst = 1'b1; tick(); rst = 1'b0;
    chk("abort_imem_req", bus.imem_req, 0);
    chk("abort_pc", bus.imem_addr, 8'h00);
    chk("abort_op", bus.op, 4'h0);
    bus.imem_ack = 1'b1; bus.imem_data = 8'h2F;
    tick();
    bus.imem_ack = 1'b0; bus.imem_data = 8'h00;
    chk("late_ack_op", bus.op, 4'h0);
    chk("late_ack_req", bus.imem_req, 0);
    tick();
    chk("late_ack_dmem", bus.dmem_req, 0);
    chk("late_ack_ex", bus.ex_stb, 0);

    // MEM instruction with a 3-cycle dmem wait.
    run = 1'b1; tick(); run = 1'b0;
    do_instr(8'h2C, 3, 1'b0, 1'b1, 1'b0, 7'h05, 8'h01);

    for (int p = 1; p < 8'h10; p++) do_instr(8'h00, 0, 1'b0, 1'b0, 1'b0, 7'h00, 8'(p + 1));

    // HLT at 0x10.
    chk("hlt_addr", bus.imem_addr, 8'h10);
    bus.imem_ack = 1'b1; bus.imem_data = 8'h40;
    tick();
    bus.imem_ack = 1'b0; bus.imem_data = 8'h00;
    chk("hlt_op", bus.op, 4'h4);
    tick();
    chk("hlt_halted", bus.halted, 1);
    chk("hlt_no_ex", bus.ex_stb, 0);
    chk("hlt_no_wb", bus.wb_stb, 0);
    chk("hlt_no_dmem", bus.dmem_req, 0);
    chk("hlt_no_imem", bus.imem_req, 0);
    chk("hlt_pc", bus.imem_addr, 8'h11);
    tick();
    chk("hlt_stay", bus.halted, 1);
    chk("hlt_stay_ex", bus.ex_stb, 0);
    run = 1'b1; tick(); run = 1'b0;
    chk("resume_halted", bus.halted, 0);
    chk("resume_req", bus.imem_req, 1);
    chk("resume_addr", bus.imem_addr, 8'h11);

    for (int p = 8'h11; p < 8'h37; p++) do_instr(8'h00, 0, 1'b0, 1'b0, 1'b0, 7'h00, 8'(p + 1));

    // Page-local branch: taken, taken back, not taken.
    do_instr(8'h3A, 0, 1'b1, 1'b1, 1'b0, 7'h29, 8'h3A);
    do_instr(8'h37, 1, 1'b1, 1'b1, 1'b0, 7'h29, 8'h37);
    do_instr(8'h3A, 0, 1'b0, 1'b1, 1'b0, 7'h29, 8'h38);

    for (int p = 8'h38; p < 8'hFF; p++) do_instr(8'h00, 0, 1'b0, 1'b0, 1'b0, 7'h00, 8'(p + 1));

    // Wrap from 0xFF.
    do_instr(8'h15, 0, 1'b0, 1'b0, 1'b1, 7'h02, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mica_sequencer.md
# mica_sequencer

Multi-cycle fetch/decode/execute sequencer for the Mica2 core. Fetches 8-bit instructions over a request/acknowledge bus and hands the opcode nibble to the external combinational opcode-decode ROM. It then registers the ROM's 7-bit control word and steps it through optional data-memory, execute and write-back cycles. Sits between instruction memory, data memory and the datapath; it owns the program counter.

## Interface
Parameters:
- PC_W, 8, program counter / instruction address width
- RESET_PC, 8'h00, PC value loaded on reset

Ports:
- clk  in  1  core clock; all state on rising edge
- rst  in  1  synchronous, active-high reset
- run  in  1  single-cycle pulse; starts execution from IDLE, resumes from HALT
- imem_req  out  1  instruction fetch request
- imem_addr  out  PC_W  fetch address (= pc)
- imem_ack  in  1  fetch complete; imem_data valid this cycle
- imem_data  in  8  instruction: [7:4] opcode, [3:0] operand
- op  out  4  opcode to decode ROM (registered instruction [7:4])
- ctl  in  7  control word returned by decode ROM (combinational in op)
- dmem_req  out  1  data-memory access request
- dmem_ack  in  1  data access complete
- flag_z  in  1  datapath zero flag, sampled in EXEC
- ctl_q  out  7  registered control word presented to datapath
- operand  out  4  registered instruction [3:0]
- ex_stb  out  1  one-cycle execute strobe
- wb_stb  out  1  one-cycle write-back strobe
- halted  out  1  high while in HALT

## Operation
- Control word bits used by sequencer: ctl[0] MEM (insert data cycle), ctl[1] WB, ctl[3] BR (branch if flag_z), ctl[6] HLT; remaining bits passed through in ctl_q only.
- States: IDLE, FETCH, DECODE, MEM, EXEC, HALT.
- IDLE: outputs idle; run=1 -> FETCH.
- FETCH: imem_req=1, imem_addr=pc; stays until imem_ack=1, then latches imem_data into ir and moves to DECODE.
- DECODE: op=ir[7:4] already stable; latches ctl into ctl_q. Next state: HLT -> HALT; else MEM -> MEM; else EXEC.
- MEM: dmem_req=1 until dmem_ack=1 -> EXEC.
- EXEC: ex_stb=1; wb_stb=ctl_q[1]. PC update: BR & flag_z -> pc <= {pc[PC_W-1:4], operand}; else pc <= pc+1. Next state FETCH.
- HALT: halted=1; pc already advanced past halt instruction; run=1 -> FETCH.
- PC increment wraps modulo 2^PC_W (8'hFF -> 8'h00); no flag.
- run ignored outside IDLE/HALT.

## Timing
- Reset (rst=1 at edge, any state): state=IDLE, pc=RESET_PC, ir=0, ctl_q=0; imem_req, dmem_req, ex_stb, wb_stb and halted all 0 the following cycle. Reset aborts an outstanding request; a late ack is ignored in IDLE.
- imem_req / dmem_req held high continuously until ack is sampled. They drop the cycle after ack. An ack in the same cycle req first rises is accepted (minimum one cycle per access).
- Minimum instruction latency with zero-wait ack: 3 cycles (FETCH, DECODE, EXEC); 4 with MEM.
- ctl is combinational from op; must be settled within DECODE cycle, registered at its end.
- ctl_q, operand stable from cycle after DECODE until next DECODE.
- HLT overrides MEM/WB/BR: no ex_stb, no wb_stb for halt instruction; pc increments in DECODE on HLT.
- flag_z sampled only in EXEC cycle.

## Structure
- Shared package/include mica_pkg: state encoding constants, ctl bit indices (CTL_MEM=0, CTL_WB=1, CTL_BR=3, CTL_HLT=6).
- One sub-module: mica_pc (PC register with reset, increment, page-local load).
- Decode ROM is not instantiated here; the parent connects op/ctl.

## Test plan
- Reset mid-FETCH with imem_req=1 -> next cycle imem_req=0, state IDLE, pc=8'h00; ack one cycle later produces no DECODE.
- run, ROM returns ctl=7'h02, zero-wait acks -> ex_stb and wb_stb high on cycle 3, pc 00->01, imem_req reasserted cycle 4.
- ctl=7'h05 with dmem_ack delayed 3 cycles -> dmem_req high exactly 4 cycles, then one ex_stb; wb_stb=0.
- ctl=7'h29 (BR), operand=4'hA, pc=8'h37, flag_z=1 -> pc=8'h3A; repeat with flag_z=0 -> pc=8'h38.
- ctl=7'h51 (HLT) at pc=8'h10 -> halted=1, no ex_stb, pc=8'h11; run pulse -> fetch at 8'h11.
- pc=8'hFF, non-branch instruction -> pc wraps to 8'h00, next imem_addr=8'h00.
